// File: rtl/dmemory_ctrl_if.sv
// dmemory_ctrl_if: CPU load/store port and programmer port of the data memory.
// CPU side : mem_read, mem_write, mem_size, mem_unsigned, address, write_data -> read_data, read_valid, err, busy
// Prog side: upg_rst_i, upg_wen_i, upg_adr_i, upg_dat_i, upg_done_i (all synchronous to the memory clock)
interface dmemory_ctrl_if #(parameter int ADDR_W = 14);
    logic              mem_read;
    logic              mem_write;
    logic [1:0]        mem_size;
    logic              mem_unsigned;
    logic [31:0]       address;
    logic [31:0]       write_data;
    logic [31:0]       read_data;
    logic              read_valid;
    logic              err;
    logic              busy;
    logic              upg_rst_i;
    logic              upg_wen_i;
    logic [ADDR_W-1:0] upg_adr_i;
    logic [31:0]       upg_dat_i;
    logic              upg_done_i;

    modport master (
        output mem_read, mem_write, mem_size, mem_unsigned, address, write_data,
        output upg_rst_i, upg_wen_i, upg_adr_i, upg_dat_i, upg_done_i,
        input  read_data, read_valid, err, busy
    );

    modport slave (
        input  mem_read, mem_write, mem_size, mem_unsigned, address, write_data,
        input  upg_rst_i, upg_wen_i, upg_adr_i, upg_dat_i, upg_done_i,
        output read_data, read_valid, err, busy
    );
endinterface

// File: rtl/dmemory_ctrl.sv
// dmemory_ctrl: 2^ADDR_W x 32 data memory with CPU load/store port and programmer (UART loader) port.
// Ports: clock, rst_n (async, active-low), bus (dmemory_ctrl_if.slave: CPU request/response + upg_* programmer).
// Macro DMEM_SUBWORD_EN: enables byte/half accesses; when undefined every access is a word access.
module dmemory_ctrl #(
    parameter int          ADDR_W    = 14,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input logic           clock,
    input logic           rst_n,
    dmemory_ctrl_if.slave bus
);
    localparam logic [1:0] RUN = 2'd0, PROG = 2'd1, FLUSH = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [31:0]       mem [2**ADDR_W];
    logic [31:0]       word_q, load_ext, wdat;
    logic              rv_q, err_q, fault_q;
    logic              run, rd, wr, in_range, misal, fault, cpu_we, prog_we;
    logic [ADDR_W-1:0] idx;
    logic [3:0]        be;

    assign run      = state_q == RUN;
    assign rd       = run && bus.mem_read;
    assign wr       = run && bus.mem_write;
    assign idx      = bus.address[ADDR_W+1:2];
    assign in_range = bus.address[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2];
    assign fault    = !in_range || misal;
    // a read+write conflict still performs the (valid) write
    assign cpu_we   = wr && !fault;
    assign prog_we  = state_q == PROG && bus.upg_wen_i;

`ifdef DMEM_SUBWORD_EN
    logic [1:0]  off_q, size_q;
    logic        uns_q;
    logic [31:0] sh;

    assign misal = bus.mem_size == 2'b11 || (bus.mem_size == 2'b01 && bus.address[0]) ||
                   (bus.mem_size == 2'b10 && bus.address[1:0] != 2'b00);
    assign be    = bus.mem_size == 2'b00 ? 4'b0001 << bus.address[1:0] :
                   bus.mem_size == 2'b01 ? (bus.address[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wdat  = bus.mem_size == 2'b00 ? {4{bus.write_data[7:0]}} :
                   bus.mem_size == 2'b01 ? {2{bus.write_data[15:0]}} : bus.write_data;
    assign sh    = word_q >> {off_q, 3'b000};
    assign load_ext = size_q == 2'b00 ? {{24{!uns_q && sh[7]}}, sh[7:0]} :
                      size_q == 2'b01 ? {{16{!uns_q && sh[15]}}, sh[15:0]} : word_q;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            off_q  <= '0;
            size_q <= '0;
            uns_q  <= 1'b0;
        end else begin
            off_q  <= bus.address[1:0];
            size_q <= bus.mem_size;
            uns_q  <= bus.mem_unsigned;
        end
    end
`else
    assign misal    = bus.address[1:0] != 2'b00;
    assign be       = 4'b1111;
    assign wdat     = bus.write_data;
    assign load_ext = word_q;
`endif

    always_comb begin
        state_d = RUN;
        state_d = state_q == RUN  ? (!bus.upg_rst_i && !bus.upg_done_i ? PROG : RUN) :
                  state_q == PROG ? (bus.upg_rst_i ? RUN : bus.upg_done_i ? FLUSH : PROG) : RUN;
    end

    // storage is never reset; CPU and programmer writes are mutually exclusive by mode
    always_ff @(posedge clock) begin
        if (prog_we)
            mem[bus.upg_adr_i] <= bus.upg_dat_i;
        else if (cpu_we)
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[idx][8*b +: 8] <= wdat[8*b +: 8];
        word_q <= mem[idx];
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            rv_q    <= 1'b0;
            err_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rv_q    <= rd && !wr;
            err_q   <= (rd || wr) && (fault || (rd && wr));
            fault_q <= fault;
        end
    end

    assign bus.read_valid = rv_q;
    assign bus.err        = err_q;
    assign bus.read_data  = rv_q && !fault_q ? load_ext : 32'h0;
    assign bus.busy       = state_q != RUN;
endmodule

// File: tb/tb_dmemory_ctrl.sv
// tb_dmemory_ctrl: scoreboard bench for dmemory_ctrl with a byte-level reference memory.
module tb_dmemory_ctrl;
    localparam int AW = 14;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmemory_ctrl_if #(.ADDR_W(AW)) bus ();
    dmemory_ctrl #(.ADDR_W(AW), .BASE_ADDR(32'h0)) dut (.clock(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        int          cyc;
        logic        v;
        logic        e;
        logic [31:0] d;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    logic [31:0] ref_mem [256];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
            total++;
            bad++;
            $display("FAIL missing_response: got nothing, expected v=%0b e=%0b d=%h at cycle %0d",
                     sbq[0].v, sbq[0].e, sbq[0].d, sbq[0].cyc);
            void'(sbq.pop_front());
        end
        if (bus.read_valid || bus.err) begin
            if (sbq.size() == 0 || sbq[0].cyc != cyc) begin
                total++;
                bad++;
                $display("FAIL unexpected_response: got v=%0b e=%0b d=%h at cycle %0d, expected none",
                         bus.read_valid, bus.err, bus.read_data, cyc);
            end else begin
                mon_e = sbq.pop_front();
                chk("read_valid", 32'(bus.read_valid), 32'(mon_e.v));
                chk("err", 32'(bus.err), 32'(mon_e.e));
                chk("read_data", bus.read_data, mon_e.d);
            end
        end
    end

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        return ref_mem[a[9:2]][8*a[1:0] +: 8];
    endfunction

    // CPU request for one cycle; when model is set the reference memory is updated and the
    // expected response (if any) is queued for the cycle after issue
    task automatic cpu_op(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd, input bit model);
        int          n;
        bit          fault;
        logic [31:0] v, ab;
        bus.mem_read     = rd;
        bus.mem_write    = wr;
        bus.mem_size     = sz;
        bus.mem_unsigned = uns;
        bus.address      = a;
        bus.write_data   = wd;
        if (model) begin
`ifdef DMEM_SUBWORD_EN
            n = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : sz == 2'd2 ? 4 : 0;
`else
            n = 4;
`endif
            fault = a >= 32'h0001_0000 || n == 0 || (a % n) != 0;
            if (wr && !fault)
                for (int i = 0; i < n; i++) begin
                    ab = a + i;
                    ref_mem[ab[9:2]][8*ab[1:0] +: 8] = wd[8*i +: 8];
                end
            v = 32'h0;
            if (rd && !wr && !fault) begin
                for (int i = 0; i < n; i++) v[8*i +: 8] = ref_byte(a + i);
                if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
            end
            if ((rd && !wr) || ((rd || wr) && (fault || (rd && wr))))
                sbq.push_back('{cyc + 1, rd && !wr, (rd || wr) && (fault || (rd && wr)), v});
        end
        @(posedge clk);
        #1;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    task automatic prog_write(input int w, input logic [31:0] d);
        bus.upg_wen_i = 1'b1;
        bus.upg_adr_i = w[AW-1:0];
        bus.upg_dat_i = d;
        @(posedge clk);
        #1;
        bus.upg_wen_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, a;
        int          k;
        bus.mem_read = 0; bus.mem_write = 0; bus.mem_size = 2'd2; bus.mem_unsigned = 0;
        bus.address = 0; bus.write_data = 0;
        bus.upg_rst_i = 1; bus.upg_wen_i = 0; bus.upg_adr_i = 0; bus.upg_dat_i = 0; bus.upg_done_i = 0;
        #1;
        chk("rst_read_valid", 32'(bus.read_valid), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_read_data", bus.read_data, 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // load the whole test window through the programmer
        bus.upg_rst_i = 1'b0;
        @(posedge clk);
        #1;
        chk("busy_prog", 32'(bus.busy), 32'd1);
        for (int w = 0; w < 256; w++) begin
            d = w == 5 ? 32'h1234_5678 : w == 8 ? 32'h0000_80F0 : $urandom;
            prog_write(w, d);
            ref_mem[w] = d;
        end
        cpu_op(1'b0, 1'b1, 2'd2, 1'b0, 32'h14, 32'hAAAA_5555, 1'b0);
        cpu_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 1'b0);
        bus.upg_done_i = 1'b1;
        @(posedge clk);
        #1;
        chk("busy_flush", 32'(bus.busy), 32'd1);
        bus.upg_done_i = 1'b0;
        bus.upg_rst_i  = 1'b1;
        @(posedge clk);
        #1;
        chk("busy_run", 32'(bus.busy), 32'd0);

        cpu_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 1'b1);
        cpu_op(1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b1);
        cpu_op(1'b0, 1'b1, 2'd0, 1'b0, 32'h11, 32'h55, 1'b1);
        cpu_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1);
        cpu_op(1'b1, 1'b0, 2'd1, 1'b0, 32'h20, 32'h0, 1'b1);
        cpu_op(1'b1, 1'b0, 2'd1, 1'b1, 32'h20, 32'h0, 1'b1);
        cpu_op(1'b1, 1'b0, 2'd0, 1'b0, 32'h21, 32'h0, 1'b1);
        cpu_op(1'b0, 1'b1, 2'd1, 1'b0, 32'h23, 32'hBEEF, 1'b1);
        cpu_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b1);
        cpu_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h0001_0000, 32'h0, 1'b1);
        cpu_op(1'b1, 1'b0, 2'd3, 1'b0, 32'h40, 32'h0, 1'b1);
        cpu_op(1'b1, 1'b1, 2'd2, 1'b0, 32'h30, 32'hCAFE_F00D, 1'b1);
        cpu_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 1'b1);

        // programmer writes are ignored while running
        prog_write(7, 32'hBAD0_BAD0);
        cpu_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h1C, 32'h0, 1'b1);

        // load in the last RUN cycle completes; then abort back to RUN without FLUSH
        bus.upg_rst_i = 1'b0;
        cpu_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 1'b1);
        chk("busy_prog2", 32'(bus.busy), 32'd1);
        bus.upg_rst_i = 1'b1;
        @(posedge clk);
        #1;
        chk("busy_abort", 32'(bus.busy), 32'd0);

        // reset in PROG with a load pending drops everything but keeps memory
        bus.upg_rst_i = 1'b0;
        cpu_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b0);
        chk("busy_prog3", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst2_read_valid", 32'(bus.read_valid), 32'd0);
        chk("rst2_err", 32'(bus.err), 32'd0);
        chk("rst2_read_data", bus.read_data, 32'd0);
        chk("rst2_busy", 32'(bus.busy), 32'd0);
        bus.upg_rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("busy_after_rst", 32'(bus.busy), 32'd0);
        cpu_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 1'b1);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            k = $urandom_range(0, 9);
            a = $urandom_range(0, 9) == 0 ? ($urandom | 32'h0001_0000) : 32'($urandom_range(0, 1023));
            cpu_op(k < 5 || k == 9, k >= 5, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   a, $urandom, 1'b1);
        end

        repeat (3) @(posedge clk);
        #1;
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d outstanding responses, expected 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dmemory_ctrl.md
DMEMORY_CTRL -- requirements
Module: dmemory_ctrl

Interface
REQ-001 Parameter ADDR_W, default 14, word-address width; memory depth SHALL be 2^ADDR_W 32-bit words.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000, byte base of the mapped window; must be aligned to 2^(ADDR_W+2).
REQ-003 Port: clock  in  1  single clock for all logic, rising edge.
REQ-004 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-005 Port: mem_read  in  1  CPU load request, one cycle.
REQ-006 Port: mem_write  in  1  CPU store request, one cycle.
REQ-007 Port: mem_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as misaligned).
REQ-008 Port: mem_unsigned  in  1  1 zero-extends loads, 0 sign-extends them.
REQ-009 Port: address  in  32  CPU byte address.
REQ-010 Port: write_data  in  32  store data, right-justified.
REQ-011 Port: read_data  out  32  extended load result.
REQ-012 Port: read_valid  out  1  one-cycle pulse qualifying read_data.
REQ-013 Port: err  out  1  one-cycle pulse: misaligned, out-of-range, reserved size, or read+write conflict.
REQ-014 Port: busy  out  1  high while the CPU port is locked out.
REQ-015 Port: upg_rst_i  in  1  programmer reset, active high; high means the programmer is inactive.
REQ-016 Port: upg_wen_i  in  1  programmer word-write enable.
REQ-017 Port: upg_adr_i  in  ADDR_W  programmer word address.
REQ-018 Port: upg_dat_i  in  32  programmer write data.
REQ-019 Port: upg_done_i  in  1  programming finished; level signal.

Function
REQ-020 All upg_* inputs SHALL be synchronous to clock; the block SHALL have no second clock domain.
REQ-021 Word index SHALL be address[ADDR_W+1:2]; in-range SHALL mean address[31:ADDR_W+2] equals BASE_ADDR[31:ADDR_W+2].
REQ-022 Alignment: a half SHALL require address[0]==0; a word SHALL require address[1:0]==00.
REQ-023 Store SHALL write in the request cycle, with per-byte enables: byte to lane address[1:0], half to lanes {address[1],0}+1..0, word to all lanes; untouched bytes SHALL be preserved.
REQ-024 Load SHALL yield read_valid and read_data exactly one cycle after the request; the selected byte or half SHALL be shifted to bit 0 and extended per mem_unsigned.
REQ-025 A faulting request SHALL perform no write; on a load, read_valid SHALL still pulse with read_data=0; err SHALL pulse in the same cycle that read_valid would.
REQ-026 mem_read and mem_write high together SHALL execute the write only, suppress read_valid, and pulse err.
REQ-027 A load in cycle N+1 to a word stored in cycle N SHALL return the new data.
REQ-028 Mode FSM states: RUN, PROG, FLUSH.
REQ-029 RUN -> PROG when upg_rst_i==0 && upg_done_i==0.
REQ-030 In PROG, upg_wen_i SHALL write upg_dat_i as a full word at upg_adr_i.
REQ-031 PROG -> FLUSH when upg_done_i==1; PROG -> RUN directly when upg_rst_i==1 (abort).
REQ-032 FLUSH SHALL last exactly one cycle and then go to RUN.
REQ-033 busy SHALL be 1 in PROG and FLUSH; CPU requests there SHALL be ignored (no write, no read_valid, no err).
REQ-034 In RUN, upg_wen_i SHALL be ignored.
REQ-035 A CPU load accepted in the last RUN cycle SHALL still complete its read_valid.

Reset
REQ-036 rst_n low SHALL force state RUN, read_data=0, read_valid=0, err=0, busy=0 immediately.
REQ-037 Reset SHALL clear a pending read; memory contents SHALL NOT be cleared.

Configuration
REQ-038 Macro DMEM_SUBWORD_EN defined: byte/half access per REQ-022..REQ-024.
REQ-039 Macro DMEM_SUBWORD_EN undefined: mem_size and mem_unsigned SHALL be ignored; every access SHALL be a word access; err SHALL flag address[1:0]!=00, out-of-range, and read+write conflict only.

Verification
REQ-040 Store word 0xDEADBEEF @0x10, then store byte 0x55 @0x11, then load word @0x10 -> read_valid next cycle with read_data=0xDEAD55EF.
REQ-041 With word 0x0000_80F0 @0x20: load half signed @0x20 -> 0xFFFF80F0; load half unsigned @0x20 -> 0x000080F0; load byte signed @0x21 -> 0xFFFFFF80.
REQ-042 Store half @0x23 -> err pulse, memory unchanged; load @0x0001_0000 (ADDR_W=14) -> err, read_valid, read_data=0.
REQ-043 upg_rst_i=0, upg_done_i=0 -> busy=1; upg_wen_i writes 0x12345678 at word 5 while a CPU store to 0x14 is ignored; upg_done_i=1 -> FLUSH, then busy=0; load @0x14 -> 0x12345678.
REQ-044 Drop rst_n in PROG with a load pending -> outputs 0, state RUN; memory word 5 retained.
